// File: rtl/pkt_sram_writer.sv
// pkt_sram_writer: pulls whole packets from the priority packet fifo, writes them
// into a circular SRAM region, emits one descriptor per packet and tracks free space.
// Latency: SRAM write one cycle after the word is accepted; descriptor the cycle after eop.
// Backpressure: a packet is started only with MAX_PKT_LEN words free and no pending
// descriptor. desc_vld is held until desc_rdy.
//
// Ports:
//   clk, rst                            clock, async active-high reset
//   in_ready/in_sop/in_eop/in_vld/in_data  fifo side, next_data is the pull request
//   sram_wr_en/sram_addr/sram_wdata     registered SRAM write port
//   desc_vld/desc_rdy/desc_addr/desc_len/desc_err  descriptor handshake to scheduler
//   rel_vld/rel_len                     space returned by downstream readers
//   free_cnt                            current free words, err: one-cycle error pulse
module pkt_sram_writer #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int MAX_PKT_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  next_data,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  desc_vld,
  input  logic                  desc_rdy,
  output logic [ADDR_WIDTH-1:0] desc_addr,
  output logic [ADDR_WIDTH:0]   desc_len,
  output logic                  desc_err,
  input  logic                  rel_vld,
  input  logic [ADDR_WIDTH:0]   rel_len,
  output logic [ADDR_WIDTH:0]   free_cnt,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] MAX_W   = (ADDR_WIDTH+1)'(MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, RECV, DESC} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] pkt_start;
  logic [ADDR_WIDTH:0]   count;
  logic                  trunc;

  logic                  in_recv;
  logic                  abort;
  logic                  drop_first;
  logic                  stray;
  logic                  store;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  trunc_nxt;
  logic [ADDR_WIDTH+1:0] free_sum;
  logic                  rel_ovf;

  assign in_recv = (state == RECV);

  // The eop word ends the pull; the fifo must not advance past the packet.
  assign next_data = in_recv && !(in_vld && in_eop);

  // A new sop mid-packet throws away what was stored and restarts at pkt_start.
  assign abort      = in_recv && in_vld && in_sop && (count != '0);
  assign drop_first = in_recv && in_vld && !in_sop && (count == '0);
  assign stray      = in_vld && !in_recv;
  assign store      = in_recv && in_vld && !drop_first && (abort || (count < MAX_W));
  assign wr_addr    = abort ? pkt_start : wr_ptr;

  always_comb begin
    cnt_nxt   = count;
    trunc_nxt = trunc;
    if (abort) begin
      cnt_nxt   = (ADDR_WIDTH+1)'(1);
      trunc_nxt = 1'b0;
    end else if (store) begin
      cnt_nxt   = count + (ADDR_WIDTH+1)'(1);
    end else begin
      trunc_nxt = 1'b1;
    end
  end

  // Release, abort give-back and this cycle's write all land in one update.
  always_comb begin
    free_sum = {1'b0, free_cnt}
             + (rel_vld ? {1'b0, rel_len} : '0)
             + (abort   ? {1'b0, count}   : '0)
             - (ADDR_WIDTH+2)'(store);
    rel_ovf  = (free_sum > {1'b0, DEPTH_W});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      pkt_start  <= '0;
      count      <= '0;
      trunc      <= 1'b0;
      free_cnt   <= DEPTH_W;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      desc_vld   <= 1'b0;
      desc_addr  <= '0;
      desc_len   <= '0;
      desc_err   <= 1'b0;
      err        <= 1'b0;
    end else begin
      sram_wr_en <= store;
      if (store) begin
        sram_addr  <= wr_addr;
        sram_wdata <= in_data;
        wr_ptr     <= wr_addr + ADDR_WIDTH'(1);
      end
      err      <= abort | drop_first | stray | rel_ovf;
      free_cnt <= rel_ovf ? DEPTH_W : free_sum[ADDR_WIDTH:0];

      case (state)
        IDLE: begin
          if (in_ready && (free_cnt >= MAX_W) && !desc_vld) begin
            state     <= RECV;
            pkt_start <= wr_ptr;
            count     <= '0;
            trunc     <= 1'b0;
          end
        end
        RECV: begin
          if (in_vld && !drop_first) begin
            count <= cnt_nxt;
            trunc <= trunc_nxt;
            if (in_eop) begin
              state     <= DESC;
              desc_vld  <= 1'b1;
              desc_addr <= pkt_start;
              desc_len  <= cnt_nxt;
              desc_err  <= trunc_nxt;
            end
          end
        end
        DESC: begin
          if (desc_vld && desc_rdy) begin
            state    <= IDLE;
            desc_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_sram_writer.sv
module tb_pkt_sram_writer;
  localparam int DW = 16, AW = 10, MAXL = 32, DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_ready = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          next_data, sram_wr_en, desc_vld, desc_err, err;
  logic          desc_rdy = 1'b1;
  logic [AW-1:0] sram_addr, desc_addr;
  logic [DW-1:0] sram_wdata;
  logic [AW:0]   desc_len, free_cnt;
  logic          rel_vld = 1'b0;
  logic [AW:0]   rel_len = '0;

  pkt_sram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_vld(in_vld), .in_data(in_data), .next_data(next_data),
    .sram_wr_en(sram_wr_en), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_addr(desc_addr),
    .desc_len(desc_len), .desc_err(desc_err), .rel_vld(rel_vld), .rel_len(rel_len),
    .free_cnt(free_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] addr; logic [AW:0] len; logic e; } desc_t;

  int    vectors = 0, miscompares = 0;
  wr_t   wr_q[$];
  desc_t desc_q[$];
  wr_t   w_exp;
  desc_t cur_desc;
  bit    desc_seen = 0;

  // reference model of the writer
  int mptr = 0, mfree = DEPTH, mstart = 0, mcnt = 0;
  bit mtrunc = 0;

  // scoreboard: SRAM writes and descriptors
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_wr_en) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL sram_write unexpected: addr=%0d data=%h", sram_addr, sram_wdata);
        end else begin
          w_exp = wr_q.pop_front();
          if (sram_addr !== w_exp.addr || sram_wdata !== w_exp.data) begin
            miscompares++;
            $display("FAIL sram_write: got addr=%0d data=%h want addr=%0d data=%h",
                     sram_addr, sram_wdata, w_exp.addr, w_exp.data);
          end
        end
      end
      if (desc_vld) begin
        if (!desc_seen) begin
          desc_seen = 1;
          vectors++;
          if (desc_q.size() == 0) begin
            miscompares++;
            $display("FAIL desc unexpected: addr=%0d len=%0d err=%b", desc_addr, desc_len, desc_err);
            cur_desc = {desc_addr, desc_len, desc_err};
          end else begin
            cur_desc = desc_q.pop_front();
          end
        end
        vectors++;
        if (desc_addr !== cur_desc.addr || desc_len !== cur_desc.len || desc_err !== cur_desc.e) begin
          miscompares++;
          $display("FAIL desc fields: got addr=%0d len=%0d err=%b want addr=%0d len=%0d err=%b",
                   desc_addr, desc_len, desc_err, cur_desc.addr, cur_desc.len, cur_desc.e);
        end
      end else begin
        desc_seen = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_ready = 0; in_vld = 0; in_sop = 0; in_eop = 0; rel_vld = 0; rel_len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wr_q.delete(); desc_q.delete(); desc_seen = 0;
    mptr = 0; mfree = DEPTH; mcnt = 0; mtrunc = 0; mstart = 0;
    @(negedge clk);
  endtask

  task automatic start_pkt();
    int t = 0;
    in_ready = 1'b1;
    while (next_data !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_ready = 1'b0;
    vectors++;
    if (next_data !== 1'b1) begin
      miscompares++;
      $display("FAIL start_pkt: next_data=%b want 1 within 50 cycles", next_data);
    end
    mstart = mptr; mcnt = 0; mtrunc = 0;
  endtask

  // One word in RECV; model updates and expected results pushed before the edge.
  task automatic send_word(input bit sop, input bit eop, input logic [DW-1:0] d, input int rel);
    bit    exp_store = 0, exp_err = 0;
    int    sum;
    wr_t   w;
    desc_t dd;
    in_vld = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    rel_vld = (rel > 0); rel_len = rel[AW:0];
    sum = mfree + rel;
    if (sop && mcnt > 0) begin
      sum += mcnt; mptr = mstart; mcnt = 0; mtrunc = 0; exp_err = 1;
    end
    if (mcnt == 0 && !sop) begin
      exp_err = 1;
    end else begin
      if (mcnt < MAXL) begin
        w.addr = mptr[AW-1:0]; w.data = d;
        wr_q.push_back(w);
        mptr = (mptr + 1) % DEPTH; mcnt++; sum--; exp_store = 1;
      end else begin
        mtrunc = 1;
      end
      if (eop) begin
        dd.addr = mstart[AW-1:0]; dd.len = mcnt[AW:0]; dd.e = mtrunc;
        desc_q.push_back(dd);
      end
    end
    if (sum > DEPTH) begin sum = DEPTH; exp_err = 1; end
    mfree = sum;
    #1;
    vectors++;
    if (next_data !== !eop) begin
      miscompares++;
      $display("FAIL next_data in RECV: got %b want %b", next_data, !eop);
    end
    @(negedge clk);
    in_vld = 0; in_sop = 0; in_eop = 0; rel_vld = 0; rel_len = '0;
    vectors++;
    if (sram_wr_en !== exp_store) begin
      miscompares++;
      $display("FAIL sram_wr_en timing: got %b want %b", sram_wr_en, exp_store);
    end
    vectors++;
    if (err !== exp_err) begin
      miscompares++;
      $display("FAIL err pulse: got %b want %b", err, exp_err);
    end
    vectors++;
    if (free_cnt !== mfree[AW:0]) begin
      miscompares++;
      $display("FAIL free_cnt after word: got %0d want %0d", free_cnt, mfree);
    end
  endtask

  task automatic wait_desc();
    int t = 0;
    while ((desc_q.size() != 0 || desc_vld) && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (desc_q.size() != 0 || desc_vld) begin
      miscompares++;
      $display("FAIL desc_drain: pending=%0d desc_vld=%b want 0/0", desc_q.size(), desc_vld);
    end
  endtask

  task automatic send_pkt(input int n, input logic [DW-1:0] base);
    start_pkt();
    for (int i = 0; i < n; i++)
      send_word(i == 0, i == n - 1, base + DW'(i), 0);
    wait_desc();
  endtask

  task automatic do_release(input int n);
    bit exp_err = 0;
    int sum;
    rel_vld = 1'b1; rel_len = n[AW:0];
    sum = mfree + n;
    if (sum > DEPTH) begin sum = DEPTH; exp_err = 1; end
    mfree = sum;
    @(negedge clk);
    rel_vld = 1'b0; rel_len = '0;
    vectors++;
    if (free_cnt !== mfree[AW:0] || err !== exp_err) begin
      miscompares++;
      $display("FAIL release: free_cnt=%0d err=%b want %0d %b", free_cnt, err, mfree, exp_err);
    end
  endtask

  // Partial packet then reset: no descriptor and all outputs back to reset values.
  task automatic test_reset();
    start_pkt();
    send_word(1, 0, 16'hEE00, 0);
    send_word(0, 0, 16'hEE01, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if (next_data !== 0 || sram_wr_en !== 0 || desc_vld !== 0 || desc_err !== 0 || err !== 0) begin
      miscompares++;
      $display("FAIL reset flags: nd=%b we=%b dv=%b de=%b err=%b want all 0",
               next_data, sram_wr_en, desc_vld, desc_err, err);
    end
    vectors++;
    if (sram_addr !== '0 || sram_wdata !== '0 || desc_addr !== '0 || desc_len !== '0) begin
      miscompares++;
      $display("FAIL reset fields: sa=%0d sd=%h da=%0d dl=%0d want 0",
               sram_addr, sram_wdata, desc_addr, desc_len);
    end
    vectors++;
    if (free_cnt !== 11'd1024) begin
      miscompares++;
      $display("FAIL reset free_cnt: got %0d want 1024", free_cnt);
    end
    do_reset();
  endtask

  task automatic test_basic();
    start_pkt();
    send_word(1, 0, 16'h1111, 0);
    send_word(0, 0, 16'h2222, 0);
    send_word(0, 0, 16'h3333, 0);
    send_word(0, 1, 16'h4444, 0);
    vectors++;
    if (desc_vld !== 1 || desc_addr !== 0 || desc_len !== 4 || desc_err !== 0 || free_cnt !== 1020) begin
      miscompares++;
      $display("FAIL basic desc: vld=%b addr=%0d len=%0d err=%b free=%0d want 1 0 4 0 1020",
               desc_vld, desc_addr, desc_len, desc_err, free_cnt);
    end
    wait_desc();
  endtask

  task automatic test_desc_hold();
    desc_rdy = 1'b0;
    start_pkt();
    send_word(1, 0, 16'hA000, 0);
    send_word(0, 0, 16'hA001, 0);
    send_word(0, 1, 16'hA002, 0);
    in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (desc_vld !== 1 || next_data !== 0) begin
        miscompares++;
        $display("FAIL desc_hold: desc_vld=%b next_data=%b want 1 0", desc_vld, next_data);
      end
      @(negedge clk);
    end
    desc_rdy = 1'b1;
    @(negedge clk);
    vectors++;
    if (desc_vld !== 0 || next_data !== 0) begin
      miscompares++;
      $display("FAIL desc_accept: desc_vld=%b next_data=%b want 0 0", desc_vld, next_data);
    end
    @(negedge clk);
    vectors++;
    if (next_data !== 1) begin
      miscompares++;
      $display("FAIL restart after accept: next_data=%b want 1", next_data);
    end
    in_ready = 1'b0;
    start_pkt();
    send_word(1, 1, 16'hA100, 0);
    wait_desc();
  endtask

  task automatic test_overlength();
    start_pkt();
    for (int i = 0; i < 40; i++)
      send_word(i == 0, i == 39, 16'h5000 + DW'(i), 0);
    wait_desc();
  endtask

  task automatic test_abort();
    start_pkt();
    send_word(1, 0, 16'hB000, 0);
    send_word(0, 0, 16'hB001, 0);
    send_word(0, 0, 16'hB002, 0);
    send_word(1, 0, 16'hC000, 0);
    send_word(0, 0, 16'hC001, 0);
    send_word(0, 1, 16'hC002, 0);
    wait_desc();
  endtask

  task automatic test_drop();
    start_pkt();
    send_word(0, 0, 16'hD000, 0);
    send_word(1, 0, 16'hD001, 0);
    send_word(0, 1, 16'hD002, 0);
    wait_desc();
    in_vld = 1'b1; in_data = 16'hDEAD;
    @(negedge clk);
    in_vld = 1'b0;
    vectors++;
    if (err !== 1 || sram_wr_en !== 0) begin
      miscompares++;
      $display("FAIL stray word in IDLE: err=%b wr_en=%b want 1 0", err, sram_wr_en);
    end
  endtask

  task automatic test_wrap();
    for (int p = 0; p < 255; p++) begin
      send_pkt(4, DW'(p * 4));
      do_release(4);
    end
    send_pkt(6, 16'h6000);
  endtask

  task automatic test_fill();
    for (int p = 0; p < 31; p++)
      send_pkt(32, DW'(p * 64));
    send_pkt(1, 16'h7000);
    in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (next_data !== 0 || free_cnt !== 31) begin
        miscompares++;
        $display("FAIL fill stall: next_data=%b free_cnt=%0d want 0 31", next_data, free_cnt);
      end
    end
    in_ready = 1'b0;
    do_release(1);
    start_pkt();
    send_word(1, 0, 16'h7100, 0);
    send_word(0, 1, 16'h7101, 8);
    vectors++;
    if (free_cnt !== 38) begin
      miscompares++;
      $display("FAIL write+release: free_cnt=%0d want 38", free_cnt);
    end
    wait_desc();
    send_pkt(2, 16'h7200);
    do_release(2000);
    vectors++;
    if (free_cnt !== 1024) begin
      miscompares++;
      $display("FAIL release saturate: free_cnt=%0d want 1024", free_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_desc_hold();
    test_overlength();
    test_abort();
    test_drop();
    do_reset();
    test_wrap();
    do_reset();
    test_fill();
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_q.size() != 0 || desc_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover expectations: writes=%0d descs=%0d want 0 0", wr_q.size(), desc_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
